// File: rtl/nlfsr_pkg.sv
// Shared types and feedback function for the NLFSR engine.
// Imported by nlfsr_engine and nlfsr_collector.
package nlfsr_pkg;

  localparam int NLFSR_MAX_W = 128;
  localparam int TAP_IDX_W   = 7;
  localparam int WARM_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } nlfsr_state_e;

  // f = s[0] ^ s[a] ^ (s[b] & s[c]) ^ ent. The state is zero-extended to NLFSR_MAX_W.
  function automatic logic nlfsr_feedback(
    input logic [NLFSR_MAX_W-1:0] s,
    input logic [TAP_IDX_W-1:0]   tap_a,
    input logic [TAP_IDX_W-1:0]   tap_b,
    input logic [TAP_IDX_W-1:0]   tap_c,
    input logic                   ent
  );
    return s[0] ^ s[tap_a] ^ (s[tap_b] & s[tap_c]) ^ ent;
  endfunction

endpackage

// File: rtl/nlfsr_collector.sv
// Output word assembler. Bits enter at the MSB, so the first bit of a word
// ends up in out_data[0]. This module also owns the out_valid/out_ready handshake.
module nlfsr_collector
  import nlfsr_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             stall
);

  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  logic [CNT_W-1:0] bit_cnt_q;
  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] asm_d;

  always_comb begin
    asm_d            = asm_q >> 1;
    asm_d[OUT_W-1]   = bit_in;
  end

  // A held word blocks further shifts until the consumer takes it.
  assign stall = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      asm_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      bit_cnt_q <= '0;
      asm_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (shift_en) begin
        asm_q <= asm_d;
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_q <= '0;
          out_data  <= asm_d;
          out_valid <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/nlfsr_engine.sv
// Seeded nonlinear-feedback shift register with warm-up and word output.
// Optional macro NLFSR_ENGINE_LOCKUP_EN enables all-zero state recovery.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no seed yet, state frozen, seed_ready high
// ST_WARM | WARMUP unconditional shifts, nothing collected, busy high
// ST_RUN  | shift on nlfsr_ce when not stalled, bits go to collector
module nlfsr_engine
  import nlfsr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAP_A  = 7,
  parameter int TAP_B  = 13,
  parameter int TAP_C  = 21,
  parameter int WARMUP = 64,
  parameter int OUT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nlfsr_ce,
  input  logic             entropy_in,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             seed_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             lockup_seen
);

  if (WIDTH < 8 || WIDTH > NLFSR_MAX_W) begin : g_bad_width
    $error("nlfsr_engine: WIDTH out of range");
  end
  if (TAP_A < 1 || TAP_A >= WIDTH || TAP_B < 1 || TAP_B >= WIDTH ||
      TAP_C < 1 || TAP_C >= WIDTH || TAP_A == TAP_B || TAP_A == TAP_C ||
      TAP_B == TAP_C) begin : g_bad_taps
    $error("nlfsr_engine: taps must be distinct and in 1..WIDTH-1");
  end
  if (WARMUP < 1 || WARMUP > 65535) begin : g_bad_warmup
    $error("nlfsr_engine: WARMUP out of range");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
    $error("nlfsr_engine: OUT_W out of range");
  end

  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARMUP - 1);

  nlfsr_state_e            state_q;
  nlfsr_state_e            state_d;
  logic [WIDTH-1:0]        nlfsr_q;
  logic [WARM_CNT_W-1:0]   warm_cnt_q;
  logic                    seed_accept;
  logic                    warm_shift;
  logic                    run_shift;
  logic                    any_shift;
  logic                    warm_last;
  logic                    fb;
  logic                    fix_zero;
  logic                    stall;

  assign seed_accept = seed_valid && seed_ready;
  assign warm_last   = (warm_cnt_q == WARM_LAST);
  assign warm_shift  = (state_q == ST_WARM) && !fix_zero;
  assign run_shift   = (state_q == ST_RUN) && nlfsr_ce && !stall &&
                       !fix_zero && !seed_accept;
  assign any_shift   = warm_shift || run_shift;
  assign fb          = nlfsr_feedback(NLFSR_MAX_W'(nlfsr_q),
                                      TAP_IDX_W'(TAP_A),
                                      TAP_IDX_W'(TAP_B),
                                      TAP_IDX_W'(TAP_C),
                                      entropy_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (seed_accept) state_d = ST_WARM;
      ST_WARM: if (warm_shift && warm_last) state_d = ST_RUN;
      ST_RUN:  if (seed_accept) state_d = ST_WARM;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seed_ready = 1'b1;
    busy       = 1'b0;
    case (state_q)
      ST_WARM: begin
        seed_ready = 1'b0;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // A recovery edge replaces the shift, so it is not counted as a warm-up shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      nlfsr_q    <= '0;
      warm_cnt_q <= '0;
    end else if (seed_accept) begin
      nlfsr_q    <= seed;
      warm_cnt_q <= '0;
    end else if (fix_zero) begin
      nlfsr_q    <= WIDTH'(1);
    end else if (any_shift) begin
      nlfsr_q <= {fb, nlfsr_q[WIDTH-1:1]};
      if (warm_shift) begin
        warm_cnt_q <= warm_cnt_q + WARM_CNT_W'(1);
      end
    end
  end

`ifdef NLFSR_ENGINE_LOCKUP_EN
  logic upd_q;
  logic lockup_q;

  // Only a freshly loaded or shifted state is inspected, so the all-zero reset value is left alone.
  assign fix_zero = upd_q && (nlfsr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q    <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      upd_q <= seed_accept || any_shift;
      if (fix_zero && !seed_accept) begin
        lockup_q <= 1'b1;
      end
    end
  end

  assign lockup_seen = lockup_q;
`else
  assign fix_zero    = 1'b0;
  assign lockup_seen = 1'b0;
`endif

  nlfsr_collector #(
    .OUT_W (OUT_W)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (seed_accept),
    .shift_en  (run_shift),
    .bit_in    (nlfsr_q[0]),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .stall     (stall)
  );

endmodule

// File: tb/tb_nlfsr_engine.sv
// Directed bench for nlfsr_engine (16-bit state, taps 2/3/5, WARMUP 4, 4-bit words).
// Long streams are checked against an independent bit-level model.
module tb_nlfsr_engine;

  localparam int W  = 16;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          nlfsr_ce;
  logic          entropy_in;
  logic          seed_valid;
  logic [W-1:0]  seed;
  logic          seed_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          lockup_seen;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [OW-1:0] exp_words [64];
  logic [W-1:0]  st_after_w0;

  always #5 clk = ~clk;

  nlfsr_engine #(
    .WIDTH  (W),
    .TAP_A  (2),
    .TAP_B  (3),
    .TAP_C  (5),
    .WARMUP (4),
    .OUT_W  (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nlfsr_ce    (nlfsr_ce),
    .entropy_in  (entropy_in),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .seed_ready  (seed_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .lockup_seen (lockup_seen)
  );

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic e);
    logic f;
    f = s[0] ^ s[2] ^ (s[3] & s[5]) ^ e;
    return {f, s[W-1:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [W-1:0] v);
    seed       = v;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    if (!out_valid) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    logic [W-1:0]  ms;
    logic [OW-1:0] wd;
    int            n;
    int            got;
    int            last;

    ms = 16'hACE1;
    repeat (4) ms = ref_step(ms, 1'b0);
    for (int w = 0; w < 64; w++) begin
      for (int b = 0; b < OW; b++) begin
        wd[b] = ms[0];
        ms    = ref_step(ms, 1'b0);
      end
      exp_words[w] = wd;
      if (w == 0) st_after_w0 = ms;
    end

    rst = 1'b1; nlfsr_ce = 1'b0; entropy_in = 1'b0;
    seed_valid = 1'b0; seed = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_seed_ready", seed_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_lockup", lockup_seen, 0);
    chk("rst_state", dut.nlfsr_q, 0);

    // warm-up length and end state from seed 1
    load_seed(16'h0001);
    n = 0;
    while (busy && n < 20) begin
      chk("warm_seed_ready", seed_ready, 0);
      tick();
      n++;
    end
    chk("warm_cycles", n, 4);
    chk("warm_end_state", dut.nlfsr_q, 16'h1000);
    chk("run_seed_ready", seed_ready, 1);

    // continuous stream, one word every 4 cycles
    nlfsr_ce = 1'b1; out_ready = 1'b1;
    load_seed(16'hACE1);
    got = 0; last = -1;
    for (int c = 0; c < 400 && got < 64; c++) begin
      tick();
      if (out_valid) begin
        chk("stream_data", out_data, exp_words[got]);
        if (last >= 0) chk("stream_gap", c - last, 4);
        last = c;
        got++;
      end
    end
    chk("stream_count", got, 64);

    // backpressure hold
    out_ready = 1'b0;
    load_seed(16'hACE1);
    wait_valid("hold_timeout", 40);
    chk("hold_first", out_data, exp_words[0]);
    chk("hold_first_state", dut.nlfsr_q, st_after_w0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp_words[0]);
      chk("hold_state", dut.nlfsr_q, st_after_w0);
    end
    out_ready = 1'b1;
    tick();
    wait_valid("release_timeout", 40);
    chk("release_data", out_data, exp_words[1]);

    // half-rate enable gives the same words
    load_seed(16'hACE1);
    got = 0; last = -1;
    for (int c = 0; c < 400 && got < 16; c++) begin
      nlfsr_ce = ~nlfsr_ce;
      tick();
      if (out_valid) begin
        chk("half_data", out_data, exp_words[got]);
        if (last >= 0) chk("half_gap", c - last, 8);
        last = c;
        got++;
      end
    end
    chk("half_count", got, 16);

    // reseed while a word is pending
    nlfsr_ce = 1'b1; out_ready = 1'b0;
    load_seed(16'h1234);
    wait_valid("reseed_timeout", 40);
    chk("reseed_ready", seed_ready, 1);
    load_seed(16'h0001);
    chk("reseed_valid_drop", out_valid, 0);
    chk("reseed_busy", busy, 1);
    repeat (4) tick();
    chk("reseed_run", busy, 0);

    // reset mid-word in RUN, then mid-WARM
    out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_state", dut.nlfsr_q, 0);
    chk("abort_seed_ready", seed_ready, 1);
    repeat (8) tick();
    chk("abort_idle_valid", out_valid, 0);
    load_seed(16'hACE1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_warm_busy", busy, 0);
    chk("abort_warm_state", dut.nlfsr_q, 0);

    // all-zero seed
    load_seed(16'h0000);
    chk("zero_loaded", dut.nlfsr_q, 0);
`ifdef NLFSR_ENGINE_LOCKUP_EN
    tick();
    chk("zero_fixed", dut.nlfsr_q, 1);
    chk("zero_lockup", lockup_seen, 1);
`else
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      tick();
      if (out_valid) begin
        chk("zero_word", out_data, 0);
        got++;
      end
    end
    chk("zero_count", got, 3);
    chk("zero_lockup", lockup_seen, 0);
    chk("zero_state", dut.nlfsr_q, 0);
`endif
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    entropy_in = 1'b1;
    load_seed(16'h0000);
    tick();
`ifdef NLFSR_ENGINE_LOCKUP_EN
    chk("entropy_state", dut.nlfsr_q, 16'h0001);
`else
    chk("entropy_state", dut.nlfsr_q, 16'h8000);
`endif
    chk("entropy_nonzero", (dut.nlfsr_q != 0), 1);
    entropy_in = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("final_lockup_clear", lockup_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nlfsr_engine.md
NLFSR_ENGINE -- requirements
Module: nlfsr_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning state register length in bits (legal range 8..128).
REQ-002 The block SHALL have parameter TAP_A, default 7, meaning linear feedback tap index.
REQ-003 The block SHALL have parameter TAP_B, default 13, meaning first AND-term tap index.
REQ-004 The block SHALL have parameter TAP_C, default 21, meaning second AND-term tap index; TAP_A/B/C distinct, each in 1..WIDTH-1.
REQ-005 The block SHALL have parameter WARMUP, default 64, meaning number of warm-up shifts after a seed (legal range 1..65535).
REQ-006 The block SHALL have parameter OUT_W, default 8, meaning output word width (legal range 1..WIDTH).
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-008 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-009 The block SHALL have port nlfsr_ce, input, 1, meaning shift enable in RUN.
REQ-010 The block SHALL have port entropy_in, input, 1, meaning external bit XORed into feedback on every shift.
REQ-011 The block SHALL have port seed_valid, input, 1, meaning seed offer.
REQ-012 The block SHALL have port seed, input, WIDTH, meaning seed value.
REQ-013 The block SHALL have port seed_ready, output, 1, meaning seed accepted when high with seed_valid.
REQ-014 The block SHALL have port out_valid, output, 1, meaning out_data holds a complete word.
REQ-015 The block SHALL have port out_ready, input, 1, meaning consumer takes the word.
REQ-016 The block SHALL have port out_data, output, OUT_W, meaning assembled output word.
REQ-017 The block SHALL have port busy, output, 1, meaning the block is in WARM.
REQ-018 The block SHALL have port lockup_seen, output, 1, meaning sticky all-zero-state flag.

Function
REQ-019 The block SHALL implement FSM states IDLE, WARM and RUN.
REQ-020 The feedback SHALL be f = s[0] ^ s[TAP_A] ^ (s[TAP_B] & s[TAP_C]) ^ entropy_in, with shift s <= {f, s[WIDTH-1:1]}.
REQ-021 seed_ready SHALL be high in IDLE and RUN, and low in WARM.
REQ-022 Seed handshake: on accept, state <= seed, collector cleared, out_valid <= 0 (pending word dropped), warm counter <= 0, and the FSM SHALL go to WARM.
REQ-023 WARM SHALL shift every cycle regardless of nlfsr_ce and SHALL leave WARM after exactly WARMUP shifts, entering RUN; busy SHALL equal (state == WARM).
REQ-024 In WARM, no output bits SHALL be collected.
REQ-025 In RUN, a shift SHALL occur iff nlfsr_ce=1 and !(out_valid && !out_ready); each shift SHALL push pre-shift s[0] into the collector at the MSB side, so the first bit of a word lands in out_data[0].
REQ-026 After OUT_W collected bits, the word SHALL be transferred to out_data and out_valid SHALL be set on the same edge as the last shift.
REQ-027 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 When out_valid and out_ready are both high, the word SHALL be consumed; a completion on the same edge SHALL keep out_valid=1 with the new word (zero-bubble).
REQ-029 nlfsr_ce=0 in RUN SHALL freeze the state and collector; an existing word SHALL remain consumable.

Reset
REQ-030 rst SHALL force IDLE, state=0, collector=0, warm counter=0, out_data=0, out_valid=0, busy=0 and lockup_seen=0, with seed_ready=1 in the first cycle after reset.
REQ-031 rst asserted in WARM or RUN SHALL abort mid-operation with no partial word emitted.

Configuration
REQ-032 With NLFSR_ENGINE_LOCKUP_EN defined, a state of all zeros after seed load or any shift SHALL be replaced on the next edge by value 1 (s[0]=1), and lockup_seen SHALL be set until rst.
REQ-033 Without NLFSR_ENGINE_LOCKUP_EN, no lockup detection SHALL be present, lockup_seen SHALL be tied 0, and an all-zero state SHALL evolve only through entropy_in.

Structure
REQ-034 A package nlfsr_pkg SHALL hold the FSM state enum and a feedback function parametrised by taps.
REQ-035 Sub-module nlfsr_collector SHALL own the bit counter, word assembly and out_valid/out_ready handshake.

Verification (WIDTH=16, TAP_A=2, TAP_B=3, TAP_C=5, WARMUP=4, OUT_W=4, entropy_in=0 unless stated)
REQ-036 The bench SHALL cover: reset, then seed 16'h0001 -> busy high for exactly 4 cycles, state 16'h1000 entering RUN, seed_ready low only during those 4 cycles.
REQ-037 The bench SHALL cover: seed 16'hACE1, nlfsr_ce=1, out_ready=1 -> 64 words match the bit-accurate reference model, with one word every 4 cycles.
REQ-038 The bench SHALL cover: out_ready=0 for 20 cycles after the first out_valid -> out_data and state unchanged throughout, and the next word is correct after release.
REQ-039 The bench SHALL cover: nlfsr_ce toggled 1/0 each cycle -> identical word sequence to REQ-037 at half rate.
REQ-040 The bench SHALL cover: seed accepted while out_valid=1 -> out_valid drops next cycle and busy=1.
REQ-041 The bench SHALL cover: seed 16'h0000 -> with NLFSR_ENGINE_LOCKUP_EN, state 16'h0001 one cycle later and lockup_seen=1; without it, all words 0 and lockup_seen=0; with entropy_in=1 the state leaves zero on the first shift.
